uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Ownership is held per message and paced by the UART core's start/busy handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         uart_tx_data,
  output logic                          uart_tx_start,
  input  logic                          uart_tx_busy,
  output logic                          timeout_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       tmo_cnt;
  logic                   last_flag;

  logic [IDX_W-1:0]       winner;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

  // First valid index strictly after ptr, wrapping, so the last owner ranks lowest.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx_c;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = IDX_W'(idx);
      if (!found && valid[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign winner = rr_pick(req_valid, rr_ptr);

  // Ready is only offered to the owner, and only while the UART core is free.
  always_comb begin
    req_ready = '0;
    if (state == SEND) begin
      req_ready[owner] = !uart_tx_busy;
    end
  end

  assign xfer = (state == SEND) && req_valid[owner] && !uart_tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= '0;
      rr_ptr        <= RR_INIT;
      tmo_cnt       <= '0;
      last_flag     <= 1'b0;
      grant         <= '0;
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      uart_tx_start <= 1'b0;
      timeout_flag  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            owner   <= winner;
            grant   <= onehot(winner);
            tmo_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            uart_tx_data  <= req_bytes[owner];
            last_flag     <= req_last[owner];
            uart_tx_start <= 1'b1;
            tmo_cnt       <= '0;
            state         <= WAIT_BUSY;
          end else if (tmo_cnt == TMO_LAST) begin
            grant        <= '0;
            rr_ptr       <= owner;
            timeout_flag <= 1'b1;
            tmo_cnt      <= '0;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Busy must be seen high before its low level can mean "frame done".
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (last_flag) begin
              grant  <= '0;
              rr_ptr <= owner;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected UART bytes go into a scoreboard
// queue at stimulus time and a monitor checks every start pulse against it.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        timeout_flag;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .uart_tx_data(uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy),
    .timeout_flag(timeout_flag)
  );

  int checks = 0;
  int failures = 0;
  int tcount = 0;
  int lock_bad = 0;
  logic lock_watch = 1'b0;
  logic force_busy = 1'b0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [9:0] exp_q [$];
  logic [1:0] glog [$];
  int busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART core model: busy rises the cycle after start and lasts 10 cycles.
  always @(posedge clk) begin
    if (uart_tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = force_busy | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait expired, got no event required event", name);
  endtask

  // Requester drivers: handshake sampled mid-cycle, next byte presented after the edge.
  initial begin
    logic [1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0] = (q0.size() > 0);
      req_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_valid[1] = (q1.size() > 0);
      req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  // Scoreboard monitor
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (uart_tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_start: got data %0h grant %0b, required no start",
                   uart_tx_data, grant);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {24'h0, uart_tx_data}, {24'h0, e[7:0]});
          check("sb_grant", {30'h0, grant}, {30'h0, e[9:8]});
        end
      end
      if (timeout_flag) tcount++;
      if (lock_watch && grant == 2'b01 && req_ready[1]) lock_bad++;
    end
  end

  initial begin
    logic [1:0] gprev;
    gprev = '0;
    forever begin
      @(negedge clk);
      if (grant !== gprev && grant != 2'b00) glog.push_back(grant);
      gprev = grant;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant !== g && n < 300);
    if (grant !== g) bound_fail(name);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_tx_start && n < 300);
    if (!uart_tx_start) bound_fail(name);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uart_tx_busy !== lvl && n < 300);
    if (uart_tx_busy !== lvl) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && grant == 2'b00 && !uart_tx_busy && !uart_tx_start)
               && n < 800);
    if (n >= 800) bound_fail(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int gate_bad;
    logic [1:0] gexp [4];
    gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
    reset = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_ready", {30'h0, req_ready}, 32'h0);
    check("rst_start", {31'h0, uart_tx_start}, 32'h0);
    check("rst_data", {24'h0, uart_tx_data}, 32'h0);
    check("rst_timeout", {31'h0, timeout_flag}, 32'h0);
    reset = 1'b0;

    // Single message from requester 0
    exp_q.push_back({2'b01, 8'h41});
    exp_q.push_back({2'b01, 8'h42});
    exp_q.push_back({2'b01, 8'h43});
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h43});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_valid[0] && n < 10);
    check("t1_grant_pre", {30'h0, grant}, 32'h0);
    check("t1_ready_pre", {31'h0, req_ready[0]}, 32'h0);
    @(negedge clk);
    check("t1_grant", {30'h0, grant}, 32'h1);
    wait_idle("t1_idle");
    check("t1_all_started", exp_q.size(), 32'h0);

    // Contention: two 2-byte messages from each requester
    do_reset();
    glog.delete();
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b01, 8'hA1});
    exp_q.push_back({2'b10, 8'hB0});
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA2});
    exp_q.push_back({2'b01, 8'hA3});
    exp_q.push_back({2'b10, 8'hB2});
    exp_q.push_back({2'b10, 8'hB3});
    q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
    q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
    q1.push_back({1'b0, 8'hB2}); q1.push_back({1'b1, 8'hB3});
    wait_idle("t2_idle");
    check("t2_grant_count", glog.size(), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) check("t2_grant_seq", {30'h0, glog[i]}, {30'h0, gexp[i]});
    end

    // Ownership lock
    do_reset();
    exp_q.push_back({2'b01, 8'h10});
    exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h20});
    q0.push_back({1'b0, 8'h10});
    wait_grant(2'b01, "t3_grant");
    lock_bad = 0;
    lock_watch = 1'b1;
    q1.push_back({1'b1, 8'h20});
    wait_start("t3_start");
    repeat (17) @(posedge clk);
    q0.push_back({1'b1, 8'h11});
    wait_idle("t3_idle");
    lock_watch = 1'b0;
    check("t3_lock_ready1", lock_bad, 32'h0);

    // Timeout: owner drops valid after a non-last byte
    do_reset();
    exp_q.push_back({2'b01, 8'h55});
    exp_q.push_back({2'b10, 8'h66});
    q0.push_back({1'b0, 8'h55});
    wait_start("t4_start");
    q1.push_back({1'b1, 8'h66});
    wait_busy(1'b1, "t4_busy_hi");
    wait_busy(1'b0, "t4_busy_lo");
    // Back in SEND one cycle after busy falls, then 16 idle cycles to the flag.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_flag && n < 100);
    check("t4_timeout_lat", n, 32'd17);
    check("t4_grant_released", {30'h0, grant}, 32'h0);
    @(negedge clk);
    check("t4_flag_pulse", {31'h0, timeout_flag}, 32'h0);
    check("t4_next_grant", {30'h0, grant}, 32'h2);
    wait_idle("t4_idle");

    // Busy gating
    do_reset();
    force_busy = 1'b1;
    exp_q.push_back({2'b01, 8'h77});
    q0.push_back({1'b1, 8'h77});
    wait_grant(2'b01, "t5_grant");
    gate_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready[0] || uart_tx_start) gate_bad++;
    end
    check("t5_gated", gate_bad, 32'h0);
    force_busy = 1'b0;
    #1;
    check("t5_ready", {31'h0, req_ready[0]}, 32'h1);
    @(negedge clk);
    check("t5_start", {31'h0, uart_tx_start}, 32'h1);
    wait_idle("t5_idle");

    // Reset mid-message while waiting for the frame to finish
    do_reset();
    exp_q.push_back({2'b01, 8'h88});
    q0.push_back({1'b0, 8'h88});
    q0.push_back({1'b1, 8'h89});
    wait_start("t6_start");
    wait_busy(1'b1, "t6_busy_hi");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    check("t6_rst_grant", {30'h0, grant}, 32'h0);
    check("t6_rst_ready", {30'h0, req_ready}, 32'h0);
    check("t6_rst_start", {31'h0, uart_tx_start}, 32'h0);
    reset = 1'b0;
    exp_q.push_back({2'b10, 8'h99});
    q1.push_back({1'b1, 8'h99});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 2'b00 && n < 20);
    check("t6_grant_req1", {30'h0, grant}, 32'h2);
    wait_idle("t6_idle");

    check("sb_empty", exp_q.size(), 32'h0);
    check("timeout_count", tcount, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
